// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: md_op opcodes and FSM states.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// W-bit unsigned restoring divider, one quotient bit per iterate cycle.
// quo_next/rem_next expose the result of the current step so the caller can capture it on the last edge.
module md_div_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         iterate,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quo_next,
   output logic [W-1:0] rem_next
);

   logic [W-1:0] quo;
   logic [W-1:0] rem;
   logic [W-1:0] dvs;
   logic [W:0]   shifted;
   logic [W:0]   diff;
   logic         fits;

   // Remainder stays below the divisor, so bit W of the difference is a clean borrow flag.
   always_comb begin
      shifted  = {rem, quo[W-1]};
      diff     = shifted - {1'b0, dvs};
      fits     = ~diff[W];
      rem_next = fits ? diff[W-1:0] : shifted[W-1:0];
      quo_next = {quo[W-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (start) begin
         quo <= dividend;
         rem <= '0;
         dvs <= divisor;
      end else if (iterate) begin
         quo <= quo_next;
         rem <= rem_next;
      end
   end

endmodule

// File: rtl/alu_md_unit.sv
// Iterative multiply/divide unit writing HI/LO; shift-add multiplier here, restoring divider in md_div_core.
// Handshake: start is taken only while busy=0; done pulses for one cycle as HI/LO take the result; flush while busy drops the op.
module alu_md_unit
   import md_pkg::*;
#(
   parameter int W       = 32,
   parameter int MUL_LAT = W,
   parameter int DIV_LAT = W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [2:0]   md_op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   md_state_e      state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   mcand;
   logic [2*W-1:0] prod;
   logic           res_neg;
   logic           rem_neg;
   logic           div_zero;
   logic [W-1:0]   a_q;

   logic           signed_op;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic           div_start;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] prod_next;
   logic [2*W-1:0] mul_res;
   logic [W-1:0]   quo_next;
   logic [W-1:0]   rem_next;
   logic [W-1:0]   quo_res;
   logic [W-1:0]   rem_res;

   // Both datapaths work on magnitudes; signs are latched at issue and applied on the final edge.
   always_comb begin
      signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
      a_neg     = signed_op & a[W-1];
      b_neg     = signed_op & b[W-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      div_start = (state == S_IDLE) && start && !flush &&
                  ((md_op == MD_DIV) || (md_op == MD_DIVU));

      mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
      prod_next = {mul_sum, prod[W-1:1]};
      mul_res   = res_neg ? -prod_next : prod_next;

      quo_res   = div_zero ? {W{1'b1}} : (res_neg ? -quo_next : quo_next);
      rem_res   = div_zero ? a_q : (rem_neg ? -rem_next : rem_next);
   end

   md_div_core #(.W(W)) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .iterate  (state == S_DIV),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_next (quo_next),
      .rem_next (rem_next)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         mcand    <= '0;
         prod     <= '0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         a_q      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  case (md_op)
                     MD_MULT, MD_MULTU: begin
                        state   <= S_MUL;
                        busy    <= 1'b1;
                        cnt     <= MUL_LOAD;
                        mcand   <= a_mag;
                        prod    <= {{W{1'b0}}, b_mag};
                        res_neg <= a_neg ^ b_neg;
                     end
                     MD_DIV, MD_DIVU: begin
                        state    <= S_DIV;
                        busy     <= 1'b1;
                        cnt      <= DIV_LOAD;
                        res_neg  <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        div_zero <= (b == '0);
                        a_q      <= a;
                     end
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  prod <= prod_next;
                  if (cnt == '0) begin
                     {hi, lo} <= mul_res;
                     state    <= S_IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            S_DIV: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  hi    <= rem_res;
                  lo    <= quo_res;
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit (W=32): directed corner cases plus random MULT/DIV against an arithmetic reference model.
module tb_alu_md_unit;

   localparam int W   = 32;
   localparam int LAT = 32;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [2:0]   md_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   alu_md_unit #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .md_op   (md_op),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: {hi, lo} from plain 64-bit arithmetic
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (op)
         3'd0: return 64'(sx * sy);
         3'd1: return ux * uy;
         3'd2: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            q = sx / sy;
            r = sx % sy;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // driver tasks: caller is positioned at a negedge
   task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      md_op = op;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(input int inj_at);
      logic [63:0] e;
      logic [31:0] h0, l0;
      int cyc;
      h0  = hi;
      l0  = lo;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         chk("done_while_busy", done, 64'd0);
         chk("hi_hold", hi, h0);
         chk("lo_hold", lo, l0);
         if (cyc == inj_at) begin
            start = 1'b1;
            md_op = 3'd3;
            a     = $urandom;
            b     = $urandom;
         end else begin
            start = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("latency", 64'(cyc), 64'(LAT));
      chk("done_pulse", done, 64'd1);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e    = exp_q.pop_front();
         m_hi = e[63:32];
         m_lo = e[31:0];
         chk("hi", hi, e[63:32]);
         chk("lo", lo, e[31:0]);
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp);
      @(negedge clk);
      exp_q.push_back(exp);
      issue(op, av, bv);
      wait_done(-1);
   endtask

   task automatic move_to(input logic [2:0] op, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      a     = v;
      @(negedge clk);
      start = 1'b0;
      if (op == 3'd4) m_hi = v;
      if (op == 3'd5) m_lo = v;
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      chk("mt_busy", busy, 64'd0);
      chk("mt_done", done, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  op;
      logic [31:0] av, bv;
      reset_n = 1'b0;
      start   = 1'b0;
      md_op   = 3'd0;
      a       = '0;
      b       = '0;
      flush   = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 64'd0);
      chk("rst_lo", lo, 64'd0);
      chk("rst_busy", busy, 64'd0);
      chk("rst_done", done, 64'd0);
      reset_n = 1'b1;

      // directed corner cases
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      do_op(3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
      do_op(3'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

      // move-to and reserved ops
      move_to(3'd5, 32'hCAFE_0001);
      move_to(3'd4, 32'h0000_1234);
      move_to(3'd6, 32'hDEAD_BEEF);
      move_to(3'd7, 32'hDEAD_BEEF);

      // flush at busy cycle 10: op abandoned, hi/lo keep pre-issue values
      @(negedge clk);
      issue(3'd0, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 64'd0);
      chk("flush_hi", hi, 64'h1234);
      chk("flush_lo", lo, m_lo);
      repeat (LAT + 2) begin
         @(negedge clk);
         chk("flush_no_done", done, 64'd0);
      end

      // flush together with start in IDLE, and flush alone in IDLE
      start = 1'b1;
      md_op = 3'd4;
      a     = 32'h5555_AAAA;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_start_busy", busy, 64'd0);
      chk("flush_start_hi", hi, m_hi);
      chk("flush_idle_lo", lo, m_lo);

      // start while busy is ignored; start in the done cycle is accepted
      exp_q.push_back(model(3'd0, 32'hFFFF_FF00, 32'd77));
      issue(3'd0, 32'hFFFF_FF00, 32'd77);
      wait_done(3);
      exp_q.push_back(model(3'd3, 32'd1000, 32'd33));
      issue(3'd3, 32'd1000, 32'd33);
      wait_done(-1);

      // reset at busy cycle 5
      @(negedge clk);
      issue(3'd1, 32'hFFFF_FFFF, 32'h1234_5678);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      chk("midrst_hi", hi, 64'd0);
      chk("midrst_lo", lo, 64'd0);
      chk("midrst_busy", busy, 64'd0);
      chk("midrst_done", done, 64'd0);

      // random MULT/DIV traffic
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 3));
         av = pick();
         bv = pick();
         do_op(op, av, bv, model(op, av, bv));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
